// File: rtl/phys_reg_free_list.sv
// Physical-register free list for the rename stage.
// A circular FIFO holds the free preg indices. A bitmap marks which pregs are
// currently free, so that a preg cannot be granted twice or freed twice.
// Up to two pregs are allocated and up to two are released per cycle.
module phys_reg_free_list #(
    parameter int unsigned NUM_PREGS = 64,
    parameter int unsigned NUM_AREGS = 32,
    parameter int unsigned PREG_W    = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              alloc_req_0,
    input  logic              alloc_req_1,
    output logic              alloc_gnt,
    output logic [PREG_W-1:0] alloc_preg_0,
    output logic [PREG_W-1:0] alloc_preg_1,
    input  logic              free_valid_0,
    input  logic [PREG_W-1:0] free_preg_0,
    input  logic              free_valid_1,
    input  logic [PREG_W-1:0] free_preg_1,
    output logic [PREG_W:0]   free_count,
    output logic              stall_rename,
    output logic              err_double_free
);

    logic [PREG_W-1:0]    fifo [NUM_PREGS];
    logic [PREG_W-1:0]    head;
    logic [PREG_W-1:0]    tail;
    logic [PREG_W-1:0]    head_p1;
    logic [PREG_W-1:0]    tail_p1;
    logic [NUM_PREGS-1:0] free_map;
    logic [1:0]           req_n;
    logic [1:0]           take_n;
    logic                 acc_0;
    logic                 acc_1;
    logic                 dup_0;
    logic                 dup_1;

    // Grant decision, allocation outputs and free-port acceptance.
    // All of these use only the registered state.
    always_comb begin
        req_n        = 2'(alloc_req_0) + 2'(alloc_req_1);
        alloc_gnt    = (req_n == 2'd0) || (free_count >= (PREG_W+1)'(req_n));
        stall_rename = (req_n != 2'd0) && !alloc_gnt;
        take_n       = alloc_gnt ? req_n : 2'd0;
        head_p1      = head + PREG_W'(1);
        tail_p1      = tail + PREG_W'(1);
        alloc_preg_0 = fifo[head];
        alloc_preg_1 = alloc_req_0 ? fifo[head_p1] : fifo[head];
        // p0 is never renamed, so a release of p0 is dropped without raising an error.
        dup_0 = free_valid_0 && (free_preg_0 != '0) && free_map[free_preg_0];
        acc_0 = free_valid_0 && (free_preg_0 != '0) && !free_map[free_preg_0];
        // When port 0 is accepted in the same cycle with the same preg, port 1 is a double free.
        dup_1 = free_valid_1 && (free_preg_1 != '0) &&
                (free_map[free_preg_1] || (acc_0 && (free_preg_1 == free_preg_0)));
        acc_1 = free_valid_1 && (free_preg_1 != '0) && !dup_1;
    end

    // FIFO storage. Reset fills it with the unmapped pregs in ascending order.
    // Accepted releases are written at tail, then at tail+1, in port order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NUM_PREGS; i++) begin
                fifo[i] <= (i < NUM_PREGS - NUM_AREGS) ? PREG_W'(i + NUM_AREGS) : '0;
            end
        end else begin
            if (acc_0) fifo[tail] <= free_preg_0;
            if (acc_1) fifo[acc_0 ? tail_p1 : tail] <= free_preg_1;
        end
    end

    // Pointers, free count and the sticky double-free flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head            <= '0;
            tail            <= PREG_W'(NUM_PREGS - NUM_AREGS);
            free_count      <= (PREG_W+1)'(NUM_PREGS - NUM_AREGS);
            err_double_free <= 1'b0;
        end else begin
            head       <= head + PREG_W'(take_n);
            tail       <= tail + PREG_W'(acc_0) + PREG_W'(acc_1);
            free_count <= free_count - (PREG_W+1)'(take_n)
                          + (PREG_W+1)'(acc_0) + (PREG_W+1)'(acc_1);
            if (dup_0 || dup_1) err_double_free <= 1'b1;
        end
    end

    // Free bitmap: releases set bits, and grants clear them afterwards so
    // that the allocation clear takes priority.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NUM_PREGS; i++) begin
                free_map[i] <= (i >= NUM_AREGS);
            end
        end else begin
            if (acc_0) free_map[free_preg_0] <= 1'b1;
            if (acc_1) free_map[free_preg_1] <= 1'b1;
            if (alloc_gnt && alloc_req_0) free_map[alloc_preg_0] <= 1'b0;
            if (alloc_gnt && alloc_req_1) free_map[alloc_preg_1] <= 1'b0;
        end
    end

endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
- Physical-register allocator for the rename stage; it sits at the opposite end of the ROB retire interface.
- Hands out free physical destination registers to rename, up to 2 per cycle.
- Takes back old destination registers released by ROB retirement, up to 2 per cycle.
- Circular FIFO of free preg indices plus a free-bitmap that blocks double allocation and double free.

Parameters:
- NUM_PREGS, 64, physical register count; power of two.
- NUM_AREGS, 32, architectural registers; p0..p(NUM_AREGS-1) are mapped at reset.
- PREG_W, 6, preg index width = log2(NUM_PREGS).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset.
- alloc_req_0  in  1  rename slot 0 needs a preg.
- alloc_req_1  in  1  rename slot 1 needs a preg.
- alloc_gnt  out  1  all requested allocations granted this cycle.
- alloc_preg_0  out  PREG_W  preg for slot 0.
- alloc_preg_1  out  PREG_W  preg for slot 1.
- free_valid_0  in  1  ROB retire port 1 releases a preg.
- free_preg_0  in  PREG_W  released preg (ROB old_reg_1).
- free_valid_1  in  1  ROB retire port 2 releases a preg.
- free_preg_1  in  PREG_W  released preg (ROB old_reg_2).
- free_count  out  PREG_W+1  number of free pregs.
- stall_rename  out  1  requests outstanding but not granted.
- err_double_free  out  1  sticky: a free was rejected.

Behaviour:
- Reset: rstn is asynchronous and active-low; clk is the clock.
  - FIFO holds NUM_AREGS..NUM_PREGS-1 in ascending order; head=0, tail=NUM_PREGS-NUM_AREGS (mod NUM_PREGS).
  - free_count=32; bitmap bits 32..63 set, all others clear; err_double_free=0.
- alloc_preg_0 = fifo[head]. alloc_preg_1 = fifo[head+1] when alloc_req_0 is high, otherwise fifo[head]. Both are combinational from registered state.
- Grant rule: n = alloc_req_0 + alloc_req_1. alloc_gnt = (n == 0) or (free_count >= n). Allocation is all-or-nothing.
- stall_rename = (n != 0) and !alloc_gnt. Both are combinational.
- On a granted request at posedge:
  - head += n, wrapping mod NUM_PREGS.
  - Bitmap bits of the granted pregs are cleared.
  - free_count -= n.
- A free on port k is accepted only when free_valid_k=1, free_preg_k != 0, and its bitmap bit is clear.
- Accepted frees are written at tail, then tail+1, in port order 0 then 1. Tail advances by the accepted count, and bitmap bits are set.
- Rejected frees:
  - Bitmap bit already set: dropped, err_double_free set (sticky until reset).
  - free_preg_k == 0: dropped silently, no error, because x0 is never renamed.
- Both free ports carrying the same preg in one cycle: port 0 is accepted, port 1 is rejected as a double free.
- Same-cycle alloc and free:
  - Grant uses the registered free_count only; pregs freed this cycle are allocatable from the next cycle.
  - free_count_next = free_count - granted + accepted.
- Freed preg equal to a preg granted in the same cycle: impossible in a legal design (it was free). The bitmap check uses the pre-update bitmap, and the allocation clear wins.
- Capacity: free_count never exceeds NUM_PREGS-1, because p0 is never in the list. Frees that would exceed this fall under the double-free rejection by construction.
- Empty (free_count=0) with any request: alloc_gnt=0, stall_rename=1, no state change from allocation.
- Wrap-around: head and tail are PREG_W-bit counters that wrap naturally.
- Reset asserted mid-operation restores the full reset state immediately, regardless of pending requests.

Test Plan:
- Reset, then alloc_req_0=alloc_req_1=1 for 1 cycle -> alloc_gnt=1, alloc_preg_0=32, alloc_preg_1=33; next cycle free_count=30, alloc_preg_0=34.
- Only alloc_req_1=1 after reset -> alloc_preg_1=32, gnt=1, free_count 31.
- 16 dual allocations -> free_count=0. Next dual request -> alloc_gnt=0, stall_rename=1, state unchanged. Then free 40 on port 0 -> next cycle single request granted with preg 40.
- Same cycle: dual alloc with free_count=1 plus free of preg 35 -> gnt=0 that cycle, free_count=2 next; dual request then granted.
- Free preg 50 while still free (after reset) -> dropped, err_double_free=1, free_count stays 32. Free preg 0 -> dropped, no error.
- Run 200 cycles of random legal alloc/free traffic so head/tail wrap past 63 -> no preg granted twice without an intervening free; free_count always equals 64-1 minus live allocations; assert rstn mid-run -> free_count=32, alloc_preg_0=32.
